react_ctrl: RTL and testbench

REACT_CTRL -- requirements
Module: react_ctrl

---
 rtl/react_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_react_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/react_ctrl.sv
// ---------------------------------------------------------------------------
// react_ctrl -- reaction-time game controller.
//
// A press in IDLE arms a trial with a pseudo-random delay. The GO lamp lights
// when the delay expires, and the player's reaction time is counted in BCD
// milliseconds until the next press. Pressing before GO is a foul. The best
// valid time of the session is kept until the next reset.
//
// Ports
//   sysclk   in   1  sole clock, rising edge
//   BTNU     in   1  synchronous active-high reset
//   tick_ms  in   1  one-cycle pulse per millisecond
//   btn      in   1  debounced reaction button (level, active-high)
//   led_go   out  1  GO lamp, high only while in GO
//   bcd      out 16  current / last time, 4 BCD digits, MSD in [15:12]
//   best     out 16  best valid time this session, 4 BCD digits
//   flag     out  2  00 IDLE, 01 ARM, 10 GO or DONE, 11 FOUL
// ---------------------------------------------------------------------------
module react_ctrl #(
    parameter int          MIN_DELAY_MS = 1000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        sysclk,
    input  logic        BTNU,
    input  logic        tick_ms,
    input  logic        btn,
    output logic        led_go,
    output logic [15:0] bcd,
    output logic [15:0] best,
    output logic [1:0]  flag
);

    // Wide enough for MIN_DELAY_MS + 2047, the largest delay that can be latched.
    localparam int          CNT_W   = $clog2(MIN_DELAY_MS + 2048);
    localparam logic [15:0] BCD_MAX = 16'h9999;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_GO, S_DONE, S_FOUL} state_t;

    state_t           state;
    state_t           next_state;
    logic             btn_r;
    logic             btn_prev;
    logic             btn_seen_low;
    logic             press;
    logic [15:0]      lfsr;
    logic [CNT_W-1:0] delay_cnt;
    logic             arm_expire;
    logic             go_timeout;
    logic [1:0]       flag_d;
    logic             led_go_d;

    // Per-digit BCD increment; 9999 saturates instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != BCD_MAX) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11 (stage 16 is the MSB), shifting left.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Press detection. btn_seen_low samples the raw button so that a button
    // held through reset release cannot look like a fresh rising edge.
    always_ff @(posedge sysclk) begin
        if (BTNU) begin
            btn_r        <= 1'b0;
            btn_prev     <= 1'b0;
            btn_seen_low <= 1'b0;
        end else begin
            btn_r        <= btn;
            btn_prev     <= btn_r;
            btn_seen_low <= btn_seen_low | ~btn;
        end
    end

    assign press = btn_r & ~btn_prev & btn_seen_low;

    // Free-running random source, advances every cycle in every state.
    always_ff @(posedge sysclk) begin
        if (BTNU) lfsr <= LFSR_SEED;
        else      lfsr <= lfsr_step(lfsr);
    end

    // A tick with one count left is the expiring tick.
    assign arm_expire = tick_ms && (delay_cnt <= CNT_W'(1));
    assign go_timeout = tick_ms && (bcd == BCD_MAX);

    // FSM: state register
    always_ff @(posedge sysclk) begin
        if (BTNU) state <= S_IDLE;
        else      state <= next_state;
    end

    // FSM: next state. Press has priority over a coincident tick in ARM and GO.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:         if (press) next_state = S_ARM;
            S_ARM: begin
                if (press)           next_state = S_FOUL;
                else if (arm_expire) next_state = S_GO;
            end
            S_GO:           if (press || go_timeout) next_state = S_DONE;
            S_DONE, S_FOUL: if (press) next_state = S_ARM;
            default:        next_state = S_IDLE;
        endcase
    end

    // FSM: outputs, decoded from the state register then registered
    always_comb begin
        flag_d   = 2'b00;
        led_go_d = 1'b0;
        case (state)
            S_ARM:  flag_d = 2'b01;
            S_GO: begin
                flag_d   = 2'b10;
                led_go_d = 1'b1;
            end
            S_DONE: flag_d = 2'b10;
            S_FOUL: flag_d = 2'b11;
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (BTNU) begin
            flag   <= 2'b00;
            led_go <= 1'b0;
        end else begin
            flag   <= flag_d;
            led_go <= led_go_d;
        end
    end

    // Delay counter, reaction time and best time
    always_ff @(posedge sysclk) begin
        if (BTNU) begin
            delay_cnt <= '0;
            bcd       <= 16'h0000;
            best      <= BCD_MAX;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FOUL: begin
                    if (press) begin
                        delay_cnt <= CNT_W'(MIN_DELAY_MS) + CNT_W'(lfsr[10:0]);
                        bcd       <= 16'h0000;
                    end
                end
                S_ARM: begin
                    if (press) begin
                        bcd <= BCD_MAX;
                    end else if (tick_ms && (delay_cnt != '0)) begin
                        delay_cnt <= delay_cnt - CNT_W'(1);
                    end
                end
                S_GO: begin
                    // A press freezes bcd; BCD digits order the same as binary.
                    // Timeout leaves best alone since it takes the tick branch.
                    if (press) begin
                        if (bcd < best) best <= bcd;
                    end else if (tick_ms) begin
                        bcd <= bcd_inc(bcd);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_react_ctrl.sv
// ---------------------------------------------------------------------------
// tb_react_ctrl -- directed self-checking bench for react_ctrl.
// A small LFSR model predicts each latched delay; all other expected values
// are hand-derived constants. Inputs change and outputs are sampled 1 ns
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_react_ctrl;

    localparam int          MIN_D = 20;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        sysclk  = 1'b0;
    logic        BTNU    = 1'b1;
    logic        tick_ms = 1'b0;
    logic        btn     = 1'b0;
    logic        led_go;
    logic [15:0] bcd;
    logic [15:0] best;
    logic [1:0]  flag;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_lfsr;
    logic [15:0] snap;
    int          expd;

    react_ctrl #(
        .MIN_DELAY_MS (MIN_D),
        .LFSR_SEED    (SEED)
    ) dut (
        .sysclk  (sysclk),
        .BTNU    (BTNU),
        .tick_ms (tick_ms),
        .btn     (btn),
        .led_go  (led_go),
        .bcd     (bcd),
        .best    (best),
        .flag    (flag)
    );

    always #5 sysclk = ~sysclk;

    // Taps given as 1-based stage numbers; stage 16 is the MSB.
    function automatic logic [15:0] lfsr_model(input logic [15:0] s);
        int   taps [4];
        logic fb;
        taps = '{16, 14, 13, 11};
        fb   = 1'b0;
        foreach (taps[i]) fb = fb ^ s[taps[i] - 1];
        return {s[14:0], fb};
    endfunction

    always @(posedge sysclk) m_lfsr <= BTNU ? SEED : lfsr_model(m_lfsr);

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t);
        tick_ms = t;
        @(posedge sysclk);
        #1;
        tick_ms = 1'b0;
    endtask

    task automatic ticks(input int k);
        repeat (k) begin
            step(1'b1);
            step(1'b0);
        end
    endtask

    // Press is registered on the first edge and acted on at the second;
    // t is the tick value at that second edge.
    task automatic press_btn(input logic t);
        btn = 1'b1;
        step(1'b0);
        snap = m_lfsr;
        step(t);
        btn = 1'b0;
    endtask

    task automatic start_trial(input string tag);
        press_btn(1'b0);
        step(1'b0);
        chk({tag, "_arm_flag"}, flag, 2'b01);
        chk({tag, "_arm_bcd"}, bcd, 16'h0000);
    endtask

    task automatic wait_go(input string tag);
        int k;
        int want;
        k    = 0;
        want = MIN_D + int'(snap[10:0]);
        while (led_go !== 1'b1 && k < 4000) begin
            ticks(1);
            k++;
        end
        chk({tag, "_delay"}, k, want);
        chk({tag, "_go_flag"}, flag, 2'b10);
    endtask

    task automatic react(input string tag, input int ms, input logic [15:0] exp_best);
        ticks(ms);
        press_btn(1'b0);
        step(1'b0);
        chk({tag, "_bcd"}, bcd, to_bcd(ms));
        chk({tag, "_flag"}, flag, 2'b10);
        chk({tag, "_led"}, led_go, 1'b0);
        chk({tag, "_best"}, best, exp_best);
    endtask

    initial begin
        // reset state
        step(1'b0);
        step(1'b0);
        chk("rst_flag", flag, 2'b00);
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_best", best, 16'h9999);
        chk("rst_led", led_go, 1'b0);
        BTNU = 1'b0;
        ticks(3);
        chk("idle_tick_bcd", bcd, 16'h0000);
        chk("idle_tick_flag", flag, 2'b00);

        // three valid trials
        start_trial("t1");
        wait_go("t1");
        react("t1", 237, 16'h0237);
        ticks(5);
        chk("done_tick_bcd", bcd, 16'h0237);
        chk("done_tick_flag", flag, 2'b10);

        start_trial("t2");
        wait_go("t2");
        react("t2", 412, 16'h0237);

        start_trial("t3");
        wait_go("t3");
        react("t3", 150, 16'h0150);

        // foul: press 5 ticks into ARM
        start_trial("foul");
        ticks(5);
        chk("foul_pre_led", led_go, 1'b0);
        press_btn(1'b0);
        step(1'b0);
        chk("foul_flag", flag, 2'b11);
        chk("foul_bcd", bcd, 16'h9999);
        chk("foul_led", led_go, 1'b0);
        chk("foul_best", best, 16'h0150);
        ticks(3);
        chk("foul_tick_bcd", bcd, 16'h9999);

        // timeout with carry checkpoints
        start_trial("refoul");
        wait_go("to");
        for (int n = 1; n <= 10000; n++) begin
            ticks(1);
            if (n inside {9, 10, 99, 100, 999, 1000, 9999})
                chk($sformatf("to_bcd_%0d", n), bcd, to_bcd(n));
            if (n == 9999) chk("to_led_9999", led_go, 1'b1);
        end
        chk("to_end_bcd", bcd, 16'h9999);
        chk("to_end_led", led_go, 1'b0);
        chk("to_end_flag", flag, 2'b10);
        chk("to_end_best", best, 16'h0150);
        ticks(2);
        chk("to_done_bcd", bcd, 16'h9999);

        // press coincident with tick in GO
        start_trial("co");
        wait_go("co");
        ticks(41);
        press_btn(1'b1);
        step(1'b0);
        chk("co_bcd", bcd, 16'h0041);
        chk("co_flag", flag, 2'b10);
        chk("co_best", best, 16'h0041);

        // press coincident with the expiring tick in ARM
        start_trial("cx");
        expd = MIN_D + int'(snap[10:0]);
        ticks(expd - 1);
        chk("cx_pre_led", led_go, 1'b0);
        press_btn(1'b1);
        step(1'b0);
        chk("cx_flag", flag, 2'b11);
        chk("cx_bcd", bcd, 16'h9999);
        chk("cx_led", led_go, 1'b0);

        // reset mid-GO with the button held
        start_trial("rg");
        wait_go("rg");
        ticks(300);
        chk("rg_bcd", bcd, 16'h0300);
        BTNU = 1'b1;
        btn  = 1'b1;
        step(1'b0);
        step(1'b0);
        BTNU = 1'b0;
        repeat (4) step(1'b0);
        chk("rg_flag", flag, 2'b00);
        chk("rg_bcd0", bcd, 16'h0000);
        chk("rg_best", best, 16'h9999);
        chk("rg_led", led_go, 1'b0);
        btn = 1'b0;
        step(1'b0);
        step(1'b0);
        chk("rg_rel_flag", flag, 2'b00);
        start_trial("rs");
        wait_go("rs");
        react("rs", 7, 16'h0007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
